// File: rtl/alu_iter.sv
// alu_iter: ALU with valid/ready handshakes on operands and result; the result is registered.
// Define ALU_ITER_SHIFT_EN to enable iterative one-bit-per-cycle SLL/SRL/SRA; otherwise those opcodes are unsupported.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             negative
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;

`ifdef ALU_ITER_SHIFT_EN
    localparam int SW = $clog2(WIDTH);
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_res;
    logic             r_outValid;
    logic             r_zero;
    logic             r_cout;
    logic             r_overflow;
    logic             r_negative;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_overflow;

`ifdef ALU_ITER_SHIFT_EN
    logic [SW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] w_shiftNext;
    logic             w_isShift;
`endif

    // Single-cycle result; for shifts this is the starting value (final when the amount is 0).
    always_comb begin
        w_sum      = '0;
        w_result   = '0;
        w_cout     = 1'b0;
        w_overflow = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum      = {1'b0, a} + {1'b0, b};
                w_result   = w_sum[WIDTH-1:0];
                w_cout     = w_sum[WIDTH];
                w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                w_result   = w_sum[WIDTH-1:0];
                w_cout     = w_sum[WIDTH];
                w_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_ITER_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: w_result = a;
`endif
            default: w_result = '0;
        endcase
    end

`ifdef ALU_ITER_SHIFT_EN
    assign w_isShift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    always_comb begin
        case (r_op)
            OP_SLL:  w_shiftNext = {r_res[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shiftNext = {1'b0, r_res[WIDTH-1:1]};
            default: w_shiftNext = {r_res[WIDTH-1], r_res[WIDTH-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_res      <= '0;
            r_outValid <= 1'b0;
            r_zero     <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
`ifdef ALU_ITER_SHIFT_EN
            r_cnt      <= '0;
            r_op       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_res      <= w_result;
                        r_zero     <= (w_result == '0);
                        r_negative <= w_result[WIDTH-1];
                        r_cout     <= w_cout;
                        r_overflow <= w_overflow;
`ifdef ALU_ITER_SHIFT_EN
                        r_op       <= op;
                        r_cnt      <= w_isShift ? b[SW-1:0] : '0;
                        if (w_isShift && (b[SW-1:0] != '0)) begin
                            r_state <= SHIFT;
                        end else begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                        end
`else
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
`endif
                    end
                end
`ifdef ALU_ITER_SHIFT_EN
                // One bit position per cycle; the last step lands the final value and flags.
                SHIFT: begin
                    r_res      <= w_shiftNext;
                    r_zero     <= (w_shiftNext == '0);
                    r_negative <= w_shiftNext[WIDTH-1];
                    r_cnt      <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_outValid;
    assign res       = r_res;
    assign zero      = r_zero;
    assign cout      = r_cout;
    assign overflow  = r_overflow;
    assign negative  = r_negative;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter (WIDTH=8) against an arithmetic reference model.
// Honours ALU_ITER_SHIFT_EN in the model so the same bench covers both builds.
`timescale 1ns/1ps
module tb_alu_iter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         zero, cout, overflow, negative;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       cout;
        logic       ovf;
        logic       neg;
        int         latency;
        int         acceptCycle;
    } exp_t;

    exp_t sbQueue[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   stallReq = 0;
    bit   forceNotReady = 1'b0;
    bit   monitorEnable = 1'b1;
    bit   presenting = 1'b0;
    bit   expectIdle = 1'b0;
    logic [7:0] heldRes;
    logic [3:0] heldFlags;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .cout(cout), .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int sx, sy, r, amt;
        sx = $signed(x);
        sy = $signed(y);
        amt = int'(y[2:0]);
        r = 0;
        e.res = '0;
        e.cout = 1'b0;
        e.ovf = 1'b0;
        e.latency = 1;
        e.acceptCycle = 0;
        case (o)
            4'd0: begin
                r = int'(x) + int'(y);
                e.res = r[7:0];
                e.cout = (r > 255);
                e.ovf = ((sx + sy) > 127) || ((sx + sy) < -128);
            end
            4'd1: begin
                r = int'(x) - int'(y);
                e.res = r[7:0];
                e.cout = (x >= y);
                e.ovf = ((sx - sy) > 127) || ((sx - sy) < -128);
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = (sx < sy) ? 8'd1 : 8'd0;
            4'd6: e.res = (x < y) ? 8'd1 : 8'd0;
`ifdef ALU_ITER_SHIFT_EN
            4'd7: begin r = int'(x) << amt; e.res = r[7:0]; e.latency = amt + 1; end
            4'd8: begin r = int'(x) >> amt; e.res = r[7:0]; e.latency = amt + 1; end
            4'd9: begin r = sx >>> amt;     e.res = r[7:0]; e.latency = amt + 1; end
`endif
            default: e.res = '0;
        endcase
        e.zero = (e.res == 8'd0);
        e.neg = e.res[7];
        return e;
    endfunction

    // Waits for in_ready (driving ignored garbage meanwhile), issues one op, records the expectation.
    task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input bit track);
        exp_t e;
        int waitCycles = 0;
        while (!in_ready) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            waitCycles++;
            if (waitCycles > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL in_ready timeout: got 0, expected 1 within 300 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        e = model(o, x, y);
        @(posedge clk); #1;
        e.acceptCycle = cycle;
        if (track) sbQueue.push_back(e);
        in_valid = 1'($urandom_range(0, 1));
        op = 4'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic waitDrain();
        int n = 0;
        in_valid = 1'b0;
        while ((sbQueue.size() != 0 || presenting || expectIdle) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: got %0d pending, expected 0", sbQueue.size());
        end
    endtask

    // Consumer: random backpressure with optional forced stall windows.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (forceNotReady) out_ready = 1'b0;
            else if (stallReq > 0) begin
                out_ready = 1'b0;
                stallReq--;
            end else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each new result and checks hold/ready behaviour.
    always @(negedge clk) begin
        if (rst_n && monitorEnable) begin
            if (expectIdle) begin
                checkOutput("out_valid drop after handshake", 32'(out_valid), 32'd0);
                checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
                expectIdle = 1'b0;
            end else if (out_valid) begin
                if (!presenting) begin
                    if (sbQueue.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected out_valid: got 1, expected 0 (res 0x%0h)", res);
                    end else begin
                        cur = sbQueue.pop_front();
                        checkOutput("res", 32'(res), 32'(cur.res));
                        checkOutput("zero", 32'(zero), 32'(cur.zero));
                        checkOutput("cout", 32'(cout), 32'(cur.cout));
                        checkOutput("overflow", 32'(overflow), 32'(cur.ovf));
                        checkOutput("negative", 32'(negative), 32'(cur.neg));
                        checkOutput("latency", 32'(cycle - cur.acceptCycle + 1), 32'(cur.latency));
                    end
                    presenting = 1'b1;
                    heldRes = res;
                    heldFlags = {zero, cout, overflow, negative};
                end else begin
                    checkOutput("res hold", 32'(res), 32'(heldRes));
                    checkOutput("flags hold", 32'({zero, cout, overflow, negative}), 32'(heldFlags));
                end
                checkOutput("in_ready while presenting", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    presenting = 1'b0;
                    expectIdle = 1'b1;
                end
            end else if (sbQueue.size() > 0) begin
                checkOutput("in_ready while computing", 32'(in_ready), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk); #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset res", 32'(res), 32'd0);
        checkOutput("reset flags", 32'({zero, cout, overflow, negative}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

        stallReq = 7;
        applyStimulus(4'd0, 8'h7F, 8'h01, 1'b1);
        applyStimulus(4'd1, 8'h00, 8'h80, 1'b1);
        applyStimulus(4'd1, 8'h05, 8'h05, 1'b1);
        applyStimulus(4'd1, 8'h80, 8'h01, 1'b1);
        applyStimulus(4'd9, 8'h90, 8'h03, 1'b1);
        applyStimulus(4'd9, 8'hA5, 8'h00, 1'b1);
        applyStimulus(4'd8, 8'hF0, 8'h07, 1'b1);
        applyStimulus(4'd7, 8'h01, 8'h01, 1'b1);
        applyStimulus(4'd15, 8'hFF, 8'hFF, 1'b1);
        applyStimulus(4'd5, 8'h80, 8'h01, 1'b1);
        applyStimulus(4'd6, 8'h80, 8'h01, 1'b1);
        applyStimulus(4'd0, 8'hFF, 8'h01, 1'b1);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'b1);
        end
        waitDrain();

        // Abort an operation with reset, then confirm nothing is presented and the block recovers.
        monitorEnable = 1'b0;
        forceNotReady = 1'b1;
        applyStimulus(4'd7, 8'h01, 8'h07, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset res", 32'(res), 32'd0);
        checkOutput("async reset flags", 32'({zero, cout, overflow, negative}), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no result after reset", 32'(out_valid), 32'd0);
        end
        presenting = 1'b0;
        expectIdle = 1'b0;
        forceNotReady = 1'b0;
        @(posedge clk); #1;
        monitorEnable = 1'b1;
        applyStimulus(4'd0, 8'h01, 8'h02, 1'b1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
